// File: rtl/sync_link_pkg.sv
// Shared definitions for the serial sync-pattern link.
//   link_state_e     : transmitter FSM states (IDLE, SYNC, DATA)
//   SYNC_W_DEFAULT   : default sync pattern length in bits
//   SYNC_PAT_DEFAULT : default sync pattern, sent MSB first
//   FAR_END_TIMEOUT  : idle cycles after which the far-end detector loses lock
//   keepalive_ok()   : legality check for a keepalive interval
package sync_link_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        DATA
    } link_state_e;

    localparam int unsigned SYNC_W_DEFAULT = 3;
    localparam logic [SYNC_W_DEFAULT-1:0] SYNC_PAT_DEFAULT = 3'b101;
    localparam int unsigned FAR_END_TIMEOUT = 128;

    // A keepalive must fire before the far end times out, and the idle
    // counter needs at least two states to be meaningful.
    function automatic bit keepalive_ok(input int unsigned keepalive);
        return (keepalive >= 2) && (keepalive < FAR_END_TIMEOUT);
    endfunction

endpackage

// File: rtl/piso_shift.sv
// Parallel-in serial-out shift register, MSB first.
//   clk, rst : clock and synchronous active-high reset (clears the register)
//   load     : capture par_in (has priority over shift)
//   shift    : shift left by one, filling with 0
//   par_in   : parallel word to load
//   ser_out  : current MSB; a flop output, so it can drive a pin directly
module piso_shift #(
    parameter int unsigned WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] par_in,
    output logic             ser_out
);

    logic [WIDTH-1:0] sreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= par_in;
        end else if (shift) begin
            sreg <= {sreg[WIDTH-2:0], 1'b0};
        end
    end

    assign ser_out = sreg[WIDTH-1];

endmodule

// File: rtl/sync_pattern_tx.sv
// Serial framing transmitter: sends each accepted word MSB first behind a
// sync pattern, and sends sync-only keepalive frames while idle.
//   clk, rst   : clock and synchronous active-high reset
//   in_valid   : in_data holds a word to send
//   in_data    : payload word
//   in_ready   : word accepted on this edge if in_valid is also high
//   dataout    : serial line (registered)
//   busy       : a frame is in progress
//   frame_done : pulse while the last bit of any frame is on dataout
//   keepalive  : pulse while the first bit of a keepalive frame is on dataout
module sync_pattern_tx
    import sync_link_pkg::*;
#(
    parameter int unsigned            DATA_W    = 8,
    parameter int unsigned            SYNC_W    = SYNC_W_DEFAULT,
    parameter logic [SYNC_W-1:0]      SYNC_PAT  = SYNC_PAT_DEFAULT,
    parameter int unsigned            KEEPALIVE = 100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              dataout,
    output logic              busy,
    output logic              frame_done,
    output logic              keepalive
);

    localparam int unsigned FRAME_W = SYNC_W + DATA_W;
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);
    localparam int unsigned IDLE_W  = $clog2(KEEPALIVE);

    localparam logic [CNT_W-1:0]  LAST_SYNC = CNT_W'(SYNC_W - 1);
    localparam logic [CNT_W-1:0]  LAST_DATA = CNT_W'(FRAME_W - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(KEEPALIVE - 1);

    if (!keepalive_ok(KEEPALIVE)) begin : g_bad_keepalive
        $error("KEEPALIVE must be >= 2 and < %0d", FAR_END_TIMEOUT);
    end

    link_state_e        state;
    logic               data_flag;
    logic [CNT_W-1:0]   bit_cnt;
    logic [CNT_W-1:0]   bit_cnt_inc;
    logic [CNT_W-1:0]   last_idx;
    logic [IDLE_W-1:0]  idle_cnt;
    logic               transfer;
    logic               ka_start;
    logic               sreg_load;
    logic               sreg_shift;
    logic [FRAME_W-1:0] sreg_par;

    assign in_ready    = (state == IDLE) && !rst;
    assign busy        = (state != IDLE);
    assign transfer    = in_valid && in_ready;
    // A data frame carries the sync pattern too, so it wins over expiry.
    assign ka_start    = (state == IDLE) && !transfer && (idle_cnt == IDLE_MAX);
    assign sreg_load   = transfer || ka_start;
    assign sreg_shift  = (state != IDLE);
    assign sreg_par    = transfer ? {SYNC_PAT, in_data} : {SYNC_PAT, {DATA_W{1'b0}}};
    assign bit_cnt_inc = bit_cnt + CNT_W'(1);
    assign last_idx    = data_flag ? LAST_DATA : LAST_SYNC;

    // The register loads on the start edge so the first sync bit is on the
    // line in the very next cycle; shifting past the last bit brings in the
    // zero fill, which is the idle level.
    piso_shift #(
        .WIDTH (FRAME_W)
    ) u_piso_shift (
        .clk     (clk),
        .rst     (rst),
        .load    (sreg_load),
        .shift   (sreg_shift),
        .par_in  (sreg_par),
        .ser_out (dataout)
    );

    // bit_cnt is the index of the frame bit currently on dataout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            data_flag  <= 1'b0;
            bit_cnt    <= '0;
            idle_cnt   <= '0;
            frame_done <= 1'b0;
            keepalive  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            keepalive  <= 1'b0;
            unique case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    if (transfer) begin
                        state     <= SYNC;
                        data_flag <= 1'b1;
                        idle_cnt  <= '0;
                    end else if (ka_start) begin
                        state      <= SYNC;
                        data_flag  <= 1'b0;
                        idle_cnt   <= '0;
                        keepalive  <= 1'b1;
                        frame_done <= (SYNC_W == 1);
                    end else begin
                        // Expiry always leaves IDLE, so this never passes IDLE_MAX.
                        idle_cnt <= idle_cnt + IDLE_W'(1);
                    end
                end
                SYNC, DATA: begin
                    if (bit_cnt == last_idx) begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                    end else begin
                        bit_cnt <= bit_cnt_inc;
                        if (bit_cnt == LAST_SYNC) begin
                            state <= DATA;
                        end
                        frame_done <= (bit_cnt_inc == last_idx);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sync_pattern_tx.md
Name: sync_pattern_tx

Overview:
Serial framing transmitter that drives the single-bit line watched by the team's serial sync-pattern detector.
- Accepts parallel words over a valid/ready handshake.
- Serialises each word MSB-first, preceded by a fixed sync pattern.
- During idle periods, inserts sync-only keepalive frames so the far-end timeout never expires.
- Sits between the parallel datapath and the serial link pin.

Parameters:
DATA_W, 8, payload bits per frame
SYNC_W, 3, sync pattern length in bits
SYNC_PAT, 3'b101, sync pattern, transmitted MSB first
KEEPALIVE, 100, idle cycles before a forced sync-only frame; must be < 128 (far-end timeout) and >= 2

Ports:
clk  input  1  clock
rst  input  1  reset
in_valid  input  1  in_data holds a word to send
in_data  input  DATA_W  payload word
in_ready  output  1  block can accept a word this cycle
dataout  output  1  serial line, registered
busy  output  1  a frame is in progress (state != IDLE)
frame_done  output  1  one-cycle pulse, registered; high in the cycle the last bit of any frame is on dataout
keepalive  output  1  one-cycle pulse, registered; high in the cycle the first bit of a keepalive frame is on dataout

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. Reset values: state IDLE, dataout 0, frame_done 0, keepalive 0, idle counter 0, shift register 0. in_ready is forced low while rst is high.
- Reset mid-frame: the frame aborts, dataout is 0 from the next edge, the payload is discarded, and no frame_done pulse is produced.
- in_ready = (state == IDLE) && !rst (combinational). A transfer occurs on a clock edge where in_valid && in_ready.
- FSM states: IDLE, SYNC, DATA.
- IDLE:
  - dataout = 0; idle counter increments each cycle, saturating at KEEPALIVE-1.
  - On a transfer: load {SYNC_PAT, in_data} into the shift register, clear the idle counter, go to SYNC with data_flag = 1.
  - Else if idle counter == KEEPALIVE-1: load SYNC_PAT, go to SYNC with data_flag = 0, pulse keepalive.
  - in_valid in the same cycle as keepalive expiry: the data frame wins (it carries the sync anyway); no keepalive pulse.
- SYNC: shift out SYNC_W bits, one per cycle. After the last sync bit:
  - data_flag = 1 -> go to DATA.
  - data_flag = 0 -> go to IDLE, frame_done coincides with the last sync bit.
- DATA: shift out DATA_W bits MSB first. frame_done coincides with bit 0, then go to IDLE.
- Timing, transfer at edge k:
  - sync bits on dataout in cycles k+1..k+SYNC_W;
  - data MSB in cycle k+SYNC_W+1, LSB in cycle k+SYNC_W+DATA_W;
  - IDLE with in_ready high in cycle k+SYNC_W+DATA_W+1.
- Every frame is followed by at least one 0 idle bit; back-to-back period is SYNC_W+DATA_W+1 cycles (12 at defaults).
- in_data and in_valid are ignored outside IDLE; the input word is captured only at the transfer edge.
- No bit stuffing: payloads may contain SYNC_PAT. Frame alignment is the receiver's responsibility.
- Idle counter: cleared on any frame start, held at 0 outside IDLE. Maximum line gap without a sync pattern is KEEPALIVE+SYNC_W+DATA_W cycles.
- Bit counter width: $clog2(SYNC_W+DATA_W+1); no wrap-around is reachable.

Decomposition:
- Shared package (sync_link_pkg):
  - state enum {IDLE, SYNC, DATA};
  - default SYNC_PAT and SYNC_W constants;
  - far-end timeout constant 128, with an elaboration check KEEPALIVE < 128.
- One sub-module, piso_shift: parallel-load, MSB-first shift register with load/shift enables, width SYNC_W+DATA_W.
- FSM, idle counter and pulse generation stay in the top module.

Test Plan:
- Single word: transfer 0xA5 at edge 10 -> dataout 1,0,1 in cycles 11-13, then 1,0,1,0,0,1,0,1 in cycles 14-21; frame_done in cycle 21; in_ready high in cycle 22.
- Back-to-back: in_valid held high with 0x00 then 0xFF -> frames start 12 cycles apart; exactly one 0 idle bit between them; busy low for exactly 1 cycle.
- Keepalive: no in_valid for 300 cycles after reset release -> keepalive pulses every 103 cycles (100 idle + 3 sync); each followed by 101 on dataout and a frame_done on the third bit.
- Collision: in_valid=1 with 0x3C in the cycle the idle counter hits 99 -> data frame sent, keepalive stays 0, idle counter cleared.
- Reset mid-frame: rst high during the 4th data bit -> dataout 0 and in_ready 0 next cycle; no frame_done; after release, the keepalive fires 100 cycles later.
- Ignored input: toggle in_data and in_valid while busy -> transmitted bits match only the word captured at the transfer edge.
